// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: state encodings and reset constants.
package if_fetch_ctrl_pkg;

  localparam int          FC_ADDR_W   = 32;
  localparam logic [31:0] FC_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    FC_S_IDLE  = 3'd0,
    FC_S_REQ   = 3'd1,
    FC_S_WAIT  = 3'd2,
    FC_S_VALID = 3'd3,
    FC_S_DROP  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: owns the PC, issues Icache requests, flags valid instructions to decode
// and applies decode/execute redirects. Optional perf counters under FC_PERF_CNT_EN.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = FC_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = FC_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              id_jump_flag_i,
  input  logic [ADDR_W-1:0] id_jump_pc_i,
  input  logic              ex_branch_flag_i,
  input  logic [ADDR_W-1:0] ex_branch_pc_i,
  input  logic              Icache_ready_i,
  input  logic              Icache_rvalid_i,
  output logic              fc_Icache_req_o,
  output logic [ADDR_W-1:0] fc_Icache_addr_o,
  output logic              fc_Icache_data_valid_o,
  output logic [ADDR_W-1:0] fc_pc_o,
  output logic              fc_jump_flag_o,
  output logic [2:0]        o_dbg_state
`ifdef FC_PERF_CNT_EN
  ,
  output logic [31:0]       fc_inst_cnt_o,
  output logic [31:0]       fc_wait_cnt_o
`endif
);

  // Handshake: a request is accepted on a clock edge where req and ready are both high;
  // exactly one rvalid pulse answers each accepted request, never before the following cycle.

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  fc_state_e         r_state;
  fc_state_e         w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] r_fc_pc;
  logic              w_fc_pc_load;
  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;

  assign w_redirect = ex_branch_flag_i | (id_jump_flag_i & ~stall_i);
  assign w_target   = (ex_branch_flag_i ? ex_branch_pc_i : id_jump_pc_i) & ALIGN_MASK;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FC_S_IDLE;
      r_pc    <= RESET_PC;
      r_fc_pc <= RESET_PC;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_fc_pc_load) r_fc_pc <= r_pc;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_pc_next        = r_pc;
    w_fc_pc_load     = 1'b0;
    fc_Icache_req_o  = 1'b0;
    fc_Icache_addr_o = r_pc;
    case (r_state)
      FC_S_IDLE: w_next_state = FC_S_REQ;
      FC_S_REQ: begin
        fc_Icache_req_o = 1'b1;
        if (Icache_ready_i) w_next_state = FC_S_WAIT;
      end
      FC_S_WAIT: begin
        if (Icache_rvalid_i) begin
          w_next_state = FC_S_VALID;
          w_fc_pc_load = 1'b1;
        end
      end
      FC_S_VALID: begin
        // Consumption overlaps with the next request so a 1-cycle Icache sustains 2 cycles/inst.
        if (!stall_i) begin
          fc_Icache_req_o  = 1'b1;
          fc_Icache_addr_o = w_pc_plus4;
          w_pc_next        = w_pc_plus4;
          w_next_state     = Icache_ready_i ? FC_S_WAIT : FC_S_REQ;
        end
      end
      FC_S_DROP: begin
        if (Icache_rvalid_i) w_next_state = FC_S_REQ;
      end
      default: w_next_state = FC_S_IDLE;
    endcase

    // A redirect masks the request; an unanswered response becomes a debt paid off in DROP.
    if (w_redirect) begin
      fc_Icache_req_o = 1'b0;
      w_pc_next       = w_target;
      w_fc_pc_load    = 1'b0;
      if (((r_state == FC_S_WAIT) || (r_state == FC_S_DROP)) && !Icache_rvalid_i)
        w_next_state = FC_S_DROP;
      else
        w_next_state = FC_S_REQ;
    end
  end

  assign fc_Icache_data_valid_o = (r_state == FC_S_VALID);
  assign fc_pc_o                = r_fc_pc;
  assign fc_jump_flag_o         = w_redirect;
  assign o_dbg_state            = r_state;

`ifdef FC_PERF_CNT_EN
  logic [31:0] r_inst_cnt;
  logic [31:0] r_wait_cnt;
  logic        w_consume;
  logic        w_wait;

  assign w_consume = (r_state == FC_S_VALID) & ~stall_i & ~w_redirect;
  assign w_wait    = ((r_state == FC_S_REQ) & ~Icache_ready_i) |
                     (((r_state == FC_S_WAIT) | (r_state == FC_S_DROP)) & ~Icache_rvalid_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_consume) r_inst_cnt <= r_inst_cnt + 32'd1;
      if (w_wait)    r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  assign fc_inst_cnt_o = r_inst_cnt;
  assign fc_wait_cnt_o = r_wait_cnt;
`endif

endmodule
